// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle controller and the datapath/memory port.
// The controller takes the master view, the datapath the slave view.
interface multicycle_control_if;
  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic        iord;
  logic        ir_write;
  logic        pc_en;
  logic [1:0]  pc_source;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [4:0]  alu_sel;
  logic        reg_write;
  logic        reg_dst;
  logic        mem_to_reg;
  logic        illegal;

  modport master (
    input  instr, zero, mem_ready,
    output mem_req, mem_we, iord, ir_write, pc_en, pc_source, alu_src_a,
           alu_src_b, alu_sel, reg_write, reg_dst, mem_to_reg, illegal
  );

  modport slave (
    output instr, zero, mem_ready,
    input  mem_req, mem_we, iord, ir_write, pc_en, pc_source, alu_src_a,
           alu_src_b, alu_sel, reg_write, reg_dst, mem_to_reg, illegal
  );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM: fetch/decode/execute/memory/writeback sequencing
// for the 32-bit datapath, with a ready-handshaked memory port.
module multicycle_control (
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_R_EXEC    = 4'd2,
    S_R_WB      = 4'd3,
    S_MEM_ADDR  = 4'd4,
    S_MEM_READ  = 4'd5,
    S_LW_WB     = 4'd6,
    S_MEM_WRITE = 4'd7,
    S_I_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [4:0] SEL_ADD  = 5'b00000;
  localparam logic [4:0] SEL_NOR  = 5'b00001;
  localparam logic [4:0] SEL_ROLV = 5'b00010;
  localparam logic [4:0] SEL_RORV = 5'b00011;
  localparam logic [4:0] SEL_NOT  = 5'b00100;

  // Returns {legal, alu_sel} for an R-type funct field.
  function automatic logic [5:0] funct_decode(input logic [5:0] funct);
    logic [5:0] res;
    case (funct)
      6'b100000: res = {1'b1, SEL_ADD};
      6'b100111: res = {1'b1, SEL_NOR};
      6'b000100: res = {1'b1, SEL_ROLV};
      6'b000110: res = {1'b1, SEL_RORV};
      6'b100110: res = {1'b1, SEL_NOT};
      default:   res = {1'b0, SEL_ADD};
    endcase
    return res;
  endfunction

  state_t      state_r;
  state_t      next_state_s;
  logic [5:0]  opcode_s;
  logic [5:0]  r_dec_s;

  logic        mem_req_s;
  logic        mem_we_s;
  logic        iord_s;
  logic        ir_write_s;
  logic        pc_en_s;
  logic [1:0]  pc_source_s;
  logic        alu_src_a_s;
  logic [1:0]  alu_src_b_s;
  logic [4:0]  alu_sel_s;
  logic        reg_write_s;
  logic        reg_dst_s;
  logic        mem_to_reg_s;
  logic        illegal_s;

  assign opcode_s = bus.instr[31:26];
  assign r_dec_s  = funct_decode(bus.instr[5:0]);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and control decode.
  always_comb begin
    next_state_s = state_r;
    mem_req_s    = 1'b0;
    mem_we_s     = 1'b0;
    iord_s       = 1'b0;
    ir_write_s   = 1'b0;
    pc_en_s      = 1'b0;
    pc_source_s  = 2'b00;
    alu_src_a_s  = 1'b0;
    alu_src_b_s  = 2'b00;
    alu_sel_s    = SEL_ADD;
    reg_write_s  = 1'b0;
    reg_dst_s    = 1'b0;
    mem_to_reg_s = 1'b0;
    illegal_s    = 1'b0;
    case (state_r)
      S_FETCH: begin
        mem_req_s   = 1'b1;
        alu_src_b_s = 2'b01;
        if (bus.mem_ready) begin
          ir_write_s   = 1'b1;
          pc_en_s      = 1'b1;
          next_state_s = S_DECODE;
        end else begin
          next_state_s = S_FETCH;
        end
      end
      S_DECODE: begin
        // ALU precomputes the branch target into ALUOut.
        alu_src_b_s = 2'b11;
        case (opcode_s)
          OP_RTYPE: begin
            if (r_dec_s[5]) begin
              next_state_s = S_R_EXEC;
            end else begin
              illegal_s    = 1'b1;
              next_state_s = S_FETCH;
            end
          end
          OP_ADDI, OP_LW, OP_SW: next_state_s = S_MEM_ADDR;
          OP_BEQ:                next_state_s = S_BRANCH;
          OP_J:                  next_state_s = S_JUMP;
          default: begin
            illegal_s    = 1'b1;
            next_state_s = S_FETCH;
          end
        endcase
      end
      S_R_EXEC: begin
        alu_src_a_s  = 1'b1;
        alu_sel_s    = r_dec_s[4:0];
        next_state_s = S_R_WB;
      end
      S_R_WB: begin
        reg_write_s  = 1'b1;
        reg_dst_s    = 1'b1;
        next_state_s = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = 2'b10;
        case (opcode_s)
          OP_LW:   next_state_s = S_MEM_READ;
          OP_SW:   next_state_s = S_MEM_WRITE;
          OP_ADDI: next_state_s = S_I_WB;
          default: next_state_s = S_FETCH;
        endcase
      end
      S_MEM_READ: begin
        mem_req_s = 1'b1;
        iord_s    = 1'b1;
        if (bus.mem_ready) begin
          next_state_s = S_LW_WB;
        end else begin
          next_state_s = S_MEM_READ;
        end
      end
      S_LW_WB: begin
        reg_write_s  = 1'b1;
        mem_to_reg_s = 1'b1;
        next_state_s = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_req_s = 1'b1;
        mem_we_s  = 1'b1;
        iord_s    = 1'b1;
        if (bus.mem_ready) begin
          next_state_s = S_FETCH;
        end else begin
          next_state_s = S_MEM_WRITE;
        end
      end
      S_I_WB: begin
        reg_write_s  = 1'b1;
        next_state_s = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_s  = 1'b1;
        pc_source_s  = 2'b01;
        pc_en_s      = bus.zero;
        next_state_s = S_FETCH;
      end
      S_JUMP: begin
        pc_en_s      = 1'b1;
        pc_source_s  = 2'b10;
        next_state_s = S_FETCH;
      end
      default: next_state_s = S_FETCH;
    endcase
  end

  // Reset masks every output at once, so an in-flight memory request drops
  // without waiting for a clock edge.
  always_comb begin
    if (rst_n) begin
      bus.mem_req    = mem_req_s;
      bus.mem_we     = mem_we_s;
      bus.iord       = iord_s;
      bus.ir_write   = ir_write_s;
      bus.pc_en      = pc_en_s;
      bus.pc_source  = pc_source_s;
      bus.alu_src_a  = alu_src_a_s;
      bus.alu_src_b  = alu_src_b_s;
      bus.alu_sel    = alu_sel_s;
      bus.reg_write  = reg_write_s;
      bus.reg_dst    = reg_dst_s;
      bus.mem_to_reg = mem_to_reg_s;
      bus.illegal    = illegal_s;
    end else begin
      bus.mem_req    = 1'b0;
      bus.mem_we     = 1'b0;
      bus.iord       = 1'b0;
      bus.ir_write   = 1'b0;
      bus.pc_en      = 1'b0;
      bus.pc_source  = 2'b00;
      bus.alu_src_a  = 1'b0;
      bus.alu_src_b  = 2'b00;
      bus.alu_sel    = 5'b00000;
      bus.reg_write  = 1'b0;
      bus.reg_dst    = 1'b0;
      bus.mem_to_reg = 1'b0;
      bus.illegal    = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle expected control vectors are
// queued with their stimulus and compared as the FSM steps through each instruction.
module tb_multicycle_control;

  logic clk;
  logic rst_n;
  multicycle_control_if bus ();

  multicycle_control dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  logic [18:0] exp_q[$];
  logic        rdy_q[$];
  logic        zero_q[$];
  string       tag_q[$];

  logic [18:0] obs;
  assign obs = {bus.mem_req, bus.mem_we, bus.iord, bus.ir_write, bus.pc_en,
                bus.pc_source, bus.alu_src_a, bus.alu_src_b, bus.alu_sel,
                bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.illegal};

  function automatic logic [18:0] ev(input logic req, input logic we, input logic io,
                                     input logic irw, input logic pce, input logic [1:0] psrc,
                                     input logic a, input logic [1:0] b, input logic [4:0] sel,
                                     input logic rw, input logic rd, input logic m2r,
                                     input logic ill);
    return {req, we, io, irw, pce, psrc, a, b, sel, rw, rd, m2r, ill};
  endfunction

  // Expected outputs of each state, written out from the control table.
  function automatic logic [18:0] e_fetch(input logic r);
    return ev(1'b1,1'b0,1'b0,r,r,2'b00,1'b0,2'b01,5'd0,1'b0,1'b0,1'b0,1'b0);
  endfunction
  function automatic logic [18:0] e_decode(input logic ill);
    return ev(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b11,5'd0,1'b0,1'b0,1'b0,ill);
  endfunction
  function automatic logic [18:0] e_rexec(input logic [4:0] sel);
    return ev(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b00,sel,1'b0,1'b0,1'b0,1'b0);
  endfunction
  function automatic logic [18:0] e_rwb();
    return ev(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,5'd0,1'b1,1'b1,1'b0,1'b0);
  endfunction
  function automatic logic [18:0] e_maddr();
    return ev(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b10,5'd0,1'b0,1'b0,1'b0,1'b0);
  endfunction
  function automatic logic [18:0] e_mread();
    return ev(1'b1,1'b0,1'b1,1'b0,1'b0,2'b00,1'b0,2'b00,5'd0,1'b0,1'b0,1'b0,1'b0);
  endfunction
  function automatic logic [18:0] e_lwwb();
    return ev(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,5'd0,1'b1,1'b0,1'b1,1'b0);
  endfunction
  function automatic logic [18:0] e_mwrite();
    return ev(1'b1,1'b1,1'b1,1'b0,1'b0,2'b00,1'b0,2'b00,5'd0,1'b0,1'b0,1'b0,1'b0);
  endfunction
  function automatic logic [18:0] e_iwb();
    return ev(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,5'd0,1'b1,1'b0,1'b0,1'b0);
  endfunction
  function automatic logic [18:0] e_branch(input logic z);
    return ev(1'b0,1'b0,1'b0,1'b0,z,2'b01,1'b1,2'b00,5'd0,1'b0,1'b0,1'b0,1'b0);
  endfunction
  function automatic logic [18:0] e_jump();
    return ev(1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,1'b0,2'b00,5'd0,1'b0,1'b0,1'b0,1'b0);
  endfunction

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [5:0] fn);
    return {op, 20'h12345, fn};
  endfunction

  task automatic check(input string t, input logic [18:0] o, input logic [18:0] e);
    checks++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", t, o, e);
    end
  endtask

  task automatic push(input string t, input logic r, input logic z, input logic [18:0] e);
    tag_q.push_back(t);
    rdy_q.push_back(r);
    zero_q.push_back(z);
    exp_q.push_back(e);
  endtask

  // One clock per queued entry: drive, sample at the falling edge, compare.
  task automatic run_queue();
    while (exp_q.size() > 0) begin
      bus.mem_ready = rdy_q.pop_front();
      bus.zero      = zero_q.pop_front();
      @(negedge clk);
      check(tag_q.pop_front(), obs, exp_q.pop_front());
      @(posedge clk);
      #1;
    end
  endtask

  logic [5:0] fn_tab[4]  = '{6'b100111, 6'b000100, 6'b000110, 6'b100110};
  logic [4:0] sel_tab[4] = '{5'b00001, 5'b00010, 5'b00011, 5'b00100};

  initial begin
    rst_n         = 1'b0;
    bus.instr     = 32'd0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    check("reset_outputs", obs, 19'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    bus.instr = mk(6'b000000, 6'b100000);
    push("add_fetch", 1'b1, 1'b0, e_fetch(1'b1));
    push("add_decode", 1'b1, 1'b0, e_decode(1'b0));
    push("add_exec", 1'b1, 1'b0, e_rexec(5'b00000));
    push("add_wb", 1'b1, 1'b0, e_rwb());
    run_queue();

    for (int i = 0; i < 4; i++) begin
      bus.instr = mk(6'b000000, fn_tab[i]);
      push("rsweep_fetch", 1'b1, 1'b0, e_fetch(1'b1));
      push("rsweep_decode", 1'b1, 1'b0, e_decode(1'b0));
      push("rsweep_exec", 1'b1, 1'b0, e_rexec(sel_tab[i]));
      push("rsweep_wb", 1'b1, 1'b0, e_rwb());
      run_queue();
    end

    bus.instr = mk(6'b000000, 6'b111111);
    push("badfunct_fetch", 1'b1, 1'b0, e_fetch(1'b1));
    push("badfunct_decode", 1'b1, 1'b0, e_decode(1'b1));
    bus.instr = mk(6'b000000, 6'b111111);
    run_queue();

    bus.instr = mk(6'b111111, 6'b100000);
    push("badop_fetch", 1'b1, 1'b0, e_fetch(1'b1));
    push("badop_decode", 1'b1, 1'b0, e_decode(1'b1));
    run_queue();

    bus.instr = mk(6'b100011, 6'b000000);
    push("lw_fetch", 1'b1, 1'b0, e_fetch(1'b1));
    push("lw_decode", 1'b1, 1'b0, e_decode(1'b0));
    push("lw_addr", 1'b1, 1'b0, e_maddr());
    push("lw_wait1", 1'b0, 1'b0, e_mread());
    push("lw_wait2", 1'b0, 1'b0, e_mread());
    push("lw_wait3", 1'b0, 1'b0, e_mread());
    push("lw_read", 1'b1, 1'b0, e_mread());
    push("lw_wb", 1'b1, 1'b0, e_lwwb());
    run_queue();

    bus.instr = mk(6'b000100, 6'b000000);
    push("beq1_fetch", 1'b1, 1'b1, e_fetch(1'b1));
    push("beq1_decode", 1'b1, 1'b1, e_decode(1'b0));
    push("beq1_branch", 1'b1, 1'b1, e_branch(1'b1));
    push("beq0_fetch", 1'b1, 1'b0, e_fetch(1'b1));
    push("beq0_decode", 1'b1, 1'b0, e_decode(1'b0));
    push("beq0_branch", 1'b1, 1'b0, e_branch(1'b0));
    run_queue();

    bus.instr = mk(6'b001000, 6'b000000);
    push("addi_fetch", 1'b1, 1'b0, e_fetch(1'b1));
    push("addi_decode", 1'b1, 1'b0, e_decode(1'b0));
    push("addi_addr", 1'b1, 1'b0, e_maddr());
    push("addi_wb", 1'b1, 1'b0, e_iwb());
    run_queue();

    bus.instr = mk(6'b101011, 6'b000000);
    push("sw_fetch", 1'b1, 1'b0, e_fetch(1'b1));
    push("sw_decode", 1'b1, 1'b0, e_decode(1'b0));
    push("sw_addr", 1'b1, 1'b0, e_maddr());
    push("sw_write", 1'b1, 1'b0, e_mwrite());
    push("sw2_fetch", 1'b1, 1'b0, e_fetch(1'b1));
    push("sw2_decode", 1'b1, 1'b0, e_decode(1'b0));
    push("sw2_addr", 1'b1, 1'b0, e_maddr());
    push("sw2_wait1", 1'b0, 1'b0, e_mwrite());
    push("sw2_wait2", 1'b0, 1'b0, e_mwrite());
    run_queue();

    // Still waiting in MEM_WRITE; reset must drop the request mid-cycle.
    bus.mem_ready = 1'b0;
    #2;
    check("sw_hold", obs, e_mwrite());
    rst_n = 1'b0;
    #1;
    check("rst_async", obs, 19'd0);
    @(posedge clk);
    #1;
    check("rst_held", obs, 19'd0);
    rst_n = 1'b1;

    bus.instr = mk(6'b000010, 6'b000000);
    push("j_fetch_wait", 1'b0, 1'b0, e_fetch(1'b0));
    push("j_fetch", 1'b1, 1'b0, e_fetch(1'b1));
    push("j_decode", 1'b1, 1'b0, e_decode(1'b0));
    push("j_jump", 1'b1, 1'b0, e_jump());
    push("post_j_fetch", 1'b1, 1'b0, e_fetch(1'b1));
    run_queue();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
